// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - shared Ethernet framing constants and unpackager state
package ethernet_pkg;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_RECV_HEAD,
        S_RECV_PIXELS,
        S_RECV_AUDIO,
        S_RECV_TAIL,
        S_DONE,
        S_DROP
    } unpack_state_t;

    localparam int          HEADER_BYTES      = 14;
    localparam logic [47:0] BROADCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DEFAULT_MAC       = 48'h69_69_5A_06_54_91;
    localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h4C42;

    function automatic logic header_ok(input logic [47:0] dst, input logic [47:0] my_mac,
                                       input logic [15:0] etype, input logic [15:0] want);
        return ((dst == my_mac) || (dst == BROADCAST_MAC)) && (etype == want);
    endfunction

endpackage

// File: rtl/dibit_to_byte.sv
// rtl/dibit_to_byte.sv - reassembles LSb-first RMII dibits into bytes
module dibit_to_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic [7:0] byte_data,
    output logic       byte_strobe
);

    logic [1:0] dibit_cnt;
    logic [5:0] shift;

    // Any low cycle on axiiv realigns to a byte boundary.
    always_ff @(posedge clk) begin
        if (rst || !axiiv) begin
            dibit_cnt <= 2'd0;
            shift     <= 6'd0;
        end else begin
            dibit_cnt <= dibit_cnt + 2'd1;
            shift     <= {axiid, shift[5:2]};
        end
    end

    assign byte_strobe = axiiv && (dibit_cnt == 2'd3);
    assign byte_data   = {axiid, shift};

endmodule

// File: rtl/ethernet_unpackager.sv
// rtl/ethernet_unpackager.sv - header check and pixel/audio payload split for received frames
module ethernet_unpackager
    import ethernet_pkg::*;
#(
    parameter logic [47:0] MY_MAC      = DEFAULT_MAC,
    parameter logic [15:0] ETHERTYPE   = DEFAULT_ETHERTYPE,
    parameter int          PIXEL_BYTES = 320,
    parameter int          AUDIO_BYTES = 160,
    parameter int          TAIL_BYTES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       pixel_axiov,
    output logic [7:0] pixel_axiod,
    output logic [8:0] pixel_index,
    output logic       audio_axiov,
    output logic [7:0] audio_axiod,
    output logic [8:0] audio_index,
    output logic       frame_done,
    output logic       frame_err
);

    logic [7:0]    byte_data;
    logic          byte_strobe;
    unpack_state_t state;
    logic [3:0]    head_cnt;
    logic [8:0]    pix_cnt;
    logic [8:0]    aud_cnt;
    logic [2:0]    tail_cnt;
    logic [47:0]   dst_mac;
    logic [7:0]    type_hi;

    dibit_to_byte u_dibit_to_byte (
        .clk        (clk),
        .rst        (rst),
        .axiiv      (axiiv),
        .axiid      (axiid),
        .byte_data  (byte_data),
        .byte_strobe(byte_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT_IDLE;
            head_cnt    <= 4'd0;
            pix_cnt     <= 9'd0;
            aud_cnt     <= 9'd0;
            tail_cnt    <= 3'd0;
            dst_mac     <= 48'd0;
            type_hi     <= 8'd0;
            pixel_axiov <= 1'b0;
            pixel_axiod <= 8'd0;
            pixel_index <= 9'd0;
            audio_axiov <= 1'b0;
            audio_axiod <= 8'd0;
            audio_index <= 9'd0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pixel_axiov <= 1'b0;
            audio_axiov <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                S_WAIT_IDLE: if (!axiiv) state <= S_IDLE;
                S_IDLE: begin
                    if (axiiv) begin
                        state    <= S_RECV_HEAD;
                        head_cnt <= 4'd0;
                        pix_cnt  <= 9'd0;
                        aud_cnt  <= 9'd0;
                    end
                end
                S_RECV_HEAD: begin
                    if (!axiiv) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (byte_strobe) begin
                        head_cnt <= head_cnt + 4'd1;
                        if (head_cnt < 4'd6) dst_mac <= {dst_mac[39:0], byte_data};
                        if (head_cnt == 4'd12) type_hi <= byte_data;
                        // Ethertype low byte is still on the wire this cycle.
                        if (head_cnt == 4'(HEADER_BYTES - 1)) begin
                            if (header_ok(dst_mac, MY_MAC, {type_hi, byte_data}, ETHERTYPE)) begin
                                state <= S_RECV_PIXELS;
                            end else begin
                                state     <= S_DROP;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
                S_RECV_PIXELS: begin
                    if (!axiiv) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (byte_strobe) begin
                        pixel_axiov <= 1'b1;
                        pixel_axiod <= byte_data;
                        pixel_index <= pix_cnt;
                        pix_cnt     <= pix_cnt + 9'd1;
                        if (pix_cnt == 9'(PIXEL_BYTES - 1)) state <= S_RECV_AUDIO;
                    end
                end
                S_RECV_AUDIO: begin
                    if (!axiiv) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (byte_strobe) begin
                        audio_axiov <= 1'b1;
                        audio_axiod <= byte_data;
                        audio_index <= aud_cnt;
                        aud_cnt     <= aud_cnt + 9'd1;
                        if (aud_cnt == 9'(AUDIO_BYTES - 1)) begin
                            state    <= S_RECV_TAIL;
                            tail_cnt <= 3'd0;
                        end
                    end
                end
                S_RECV_TAIL: begin
                    if (!axiiv) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (byte_strobe) begin
                        tail_cnt <= tail_cnt + 3'd1;
                        if (tail_cnt == 3'(TAIL_BYTES - 1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!axiiv) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_DROP:  if (!axiiv) state <= S_IDLE;
                default: state <= S_WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_unpackager.sv
// tb/tb_ethernet_unpackager.sv - scoreboard bench for ethernet_unpackager
module tb_ethernet_unpackager;

    localparam logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91;
    localparam logic [15:0] ETYPE  = 16'h4C42;

    typedef struct {
        logic [8:0] idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'd0;
    logic       pixel_axiov, audio_axiov, frame_done, frame_err;
    logic [7:0] pixel_axiod, audio_axiod;
    logic [8:0] pixel_index, audio_index;

    exp_t pix_q[$];
    exp_t aud_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;
    int   pix_pulses, aud_pulses, done_cnt, err_cnt;
    bit   first_pix_pending = 0;
    logic [7:0] first_pix;

    ethernet_unpackager dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .pixel_axiov(pixel_axiov), .pixel_axiod(pixel_axiod), .pixel_index(pixel_index),
        .audio_axiov(audio_axiov), .audio_axiod(audio_axiod), .audio_index(audio_index),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            n_assert++;
            if ({pixel_axiov, pixel_axiod, pixel_index, audio_axiov, audio_axiod, audio_index,
                 frame_done, frame_err} !== 38'd0) begin
                n_fail++;
                $display("FAIL in_reset_outputs pix=%b/%h/%0d aud=%b/%h/%0d done=%b err=%b required all 0",
                         pixel_axiov, pixel_axiod, pixel_index, audio_axiov, audio_axiod,
                         audio_index, frame_done, frame_err);
            end
        end
        if (pixel_axiov === 1'b1) begin
            pix_pulses++;
            n_assert++;
            if (first_pix_pending) begin
                first_pix         = pixel_axiod;
                first_pix_pending = 0;
            end
            if (pix_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_unexpected index=%0d data=%h required no pulse", pixel_index, pixel_axiod);
            end else begin
                e = pix_q.pop_front();
                if (pixel_index !== e.idx || pixel_axiod !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pixel_byte got idx=%0d data=%h cyc=%0d required idx=%0d data=%h cyc=%0d",
                             pixel_index, pixel_axiod, cyc, e.idx, e.data, e.cyc);
                end
            end
        end
        if (audio_axiov === 1'b1) begin
            aud_pulses++;
            n_assert++;
            if (aud_q.size() == 0) begin
                n_fail++;
                $display("FAIL audio_unexpected index=%0d data=%h required no pulse", audio_index, audio_axiod);
            end else begin
                e = aud_q.pop_front();
                if (audio_index !== e.idx || audio_axiod !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL audio_byte got idx=%0d data=%h cyc=%0d required idx=%0d data=%h cyc=%0d",
                             audio_index, audio_axiod, cyc, e.idx, e.data, e.cyc);
                end
            end
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 && frame_err === 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL done_err_overlap done=1 err=1 required at most one");
        end
    end

    function automatic logic [7:0] frame_byte(input int i, input logic [47:0] dst,
                                              input logic [15:0] et, input int pix_base);
        if (i < 6)   return dst[8*(5-i) +: 8];
        if (i < 12)  return 8'(8'h10 + i);
        if (i == 12) return et[15:8];
        if (i == 13) return et[7:0];
        if (i < 334) return 8'((i - 14 + pix_base) % 256);
        if (i < 494) return 8'(8'hA0 + (i - 334) % 16);
        if (i < 498) return 8'(8'hC3 ^ i);
        return 8'h5A;
    endfunction

    task automatic idle(input int n);
        axiiv = 1'b0;
        axiid = 2'd0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        pix_pulses = 0;
        aud_pulses = 0;
        done_cnt   = 0;
        err_cnt    = 0;
    endtask

    // stop_dibit < 0 sends the whole frame; rst_at >= 0 pulses reset for 3 cycles at that dibit.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int pix_base,
                              input int stop_dibit, input int junk, input int rst_at,
                              input int gap, input bit accept);
        int         total;
        int         bi;
        logic [7:0] b;
        exp_t       e;
        total = (stop_dibit >= 0) ? stop_dibit : 4 * (498 + junk);
        for (int k = 0; k < total; k++) begin
            bi = k / 4;
            b  = frame_byte(bi, dst, et, pix_base);
            if (k == rst_at) rst = 1'b1;
            if (rst_at >= 0 && k == rst_at + 3) rst = 1'b0;
            axiiv = 1'b1;
            axiid = b[2*(k%4) +: 2];
            if (k % 4 == 3 && accept && (rst_at < 0 || k < rst_at)) begin
                e.data = b;
                e.cyc  = cyc + 1;
                if (bi >= 14 && bi < 334) begin
                    e.idx = 9'(bi - 14);
                    pix_q.push_back(e);
                end else if (bi >= 334 && bi < 494) begin
                    e.idx = 9'(bi - 334);
                    aud_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle(gap);
    endtask

    task automatic check_frame(input string name, input int exp_pix, input int exp_aud,
                               input int exp_done, input int exp_err);
        n_assert++;
        if (pix_pulses != exp_pix || aud_pulses != exp_aud || done_cnt != exp_done ||
            err_cnt != exp_err || pix_q.size() != 0 || aud_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s got pix=%0d aud=%0d done=%0d err=%0d left=%0d/%0d required pix=%0d aud=%0d done=%0d err=%0d left=0/0",
                     name, pix_pulses, aud_pulses, done_cnt, err_cnt, pix_q.size(), aud_q.size(),
                     exp_pix, exp_aud, exp_done, exp_err);
        end
        pix_q.delete();
        aud_q.delete();
        clear_counts();
    endtask

    task automatic test_reset();
        clear_counts();
        rst   = 1'b1;
        axiiv = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_assert++;
        if (pixel_axiov !== 1'b0 || pixel_axiod !== 8'd0 || pixel_index !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_pixel got %b/%h/%0d required 0/00/0", pixel_axiov, pixel_axiod, pixel_index);
        end
        n_assert++;
        if (audio_axiov !== 1'b0 || audio_axiod !== 8'd0 || audio_index !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_audio got %b/%h/%0d required 0/00/0", audio_axiov, audio_axiod, audio_index);
        end
        n_assert++;
        if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got done=%b err=%b required 0 0", frame_done, frame_err);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        send_frame(MY_MAC, ETYPE, 0, -1, 0, -1, 4, 1);
        check_frame("good_frame", 320, 160, 1, 0);
    endtask

    task automatic test_dibit_order();
        first_pix_pending = 1;
        send_frame(MY_MAC, ETYPE, 8'h39, -1, 0, -1, 4, 1);
        n_assert++;
        if (first_pix_pending || first_pix !== 8'h39) begin
            n_fail++;
            $display("FAIL dibit_order got %h required 39", first_pix);
        end
        check_frame("dibit_frame", 320, 160, 1, 0);
    endtask

    task automatic test_header_filter();
        send_frame(48'hFFFF_FFFF_FFFF, ETYPE, 0, -1, 0, -1, 4, 1);
        check_frame("broadcast", 320, 160, 1, 0);
        send_frame(48'h0, ETYPE, 0, -1, 0, -1, 4, 0);
        check_frame("bad_dest", 0, 0, 0, 1);
        send_frame(MY_MAC, 16'h0800, 0, -1, 0, -1, 4, 0);
        check_frame("bad_type", 0, 0, 0, 1);
    endtask

    task automatic test_truncation();
        send_frame(MY_MAC, ETYPE, 0, 4 * (14 + 100) + 2, 0, -1, 4, 1);
        check_frame("truncated", 100, 0, 0, 1);
        send_frame(MY_MAC, ETYPE, 7, -1, 0, -1, 4, 1);
        check_frame("after_truncation", 320, 160, 1, 0);
    endtask

    task automatic test_reset_mid();
        send_frame(MY_MAC, ETYPE, 0, -1, 0, 4 * (14 + 50), 4, 1);
        check_frame("reset_mid", 50, 0, 0, 0);
        send_frame(MY_MAC, ETYPE, 3, -1, 0, -1, 4, 1);
        check_frame("after_reset", 320, 160, 1, 0);
    endtask

    task automatic test_back_to_back();
        send_frame(MY_MAC, ETYPE, 11, -1, 3, -1, 1, 1);
        send_frame(48'hFFFF_FFFF_FFFF, ETYPE, 200, -1, 3, -1, 1, 1);
        idle(3);
        check_frame("back_to_back", 640, 320, 2, 0);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_dibit_order();
        test_header_filter();
        test_truncation();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ethernet_unpackager.md
Name: ethernet_unpackager

Overview:
- Receive-side counterpart of the FPGA1 Ethernet packager; sits on the FPGA2 side after the RMII PHY interface, where preamble/SFD are already stripped.
- Reassembles the LSb-first 2-bit dibit stream into bytes and checks the 14-byte MAC header.
- Splits the payload into a pixel byte stream and an audio byte stream, skips the 4-byte FCS tail, and reports frame completion or error.

Parameters:
- MY_MAC, 48'h69_69_5A_06_54_91, accepted destination MAC. Broadcast 48'hFFFF_FFFF_FFFF is also accepted.
- ETHERTYPE, 16'h4C42, required ethertype.
- PIXEL_BYTES, 320, payload bytes routed to the pixel stream (1..511).
- AUDIO_BYTES, 160, payload bytes routed to the audio stream (1..511).
- TAIL_BYTES, 4, FCS bytes consumed and discarded.

Ports:
- clk  in  1  system clock (50 MHz RMII domain)
- rst  in  1  synchronous, active-high reset
- axiiv  in  1  dibit valid; high for the whole frame, low between frames
- axiid  in  2  dibit; first dibit of each byte carries byte bits [1:0]
- pixel_axiov  out  1  pixel byte valid (single-cycle pulse)
- pixel_axiod  out  8  pixel byte
- pixel_index  out  9  index of pixel_axiod within frame, 0..PIXEL_BYTES-1
- audio_axiov  out  1  audio byte valid (single-cycle pulse)
- audio_axiod  out  8  audio byte
- audio_index  out  9  index of audio_axiod within frame, 0..AUDIO_BYTES-1
- frame_done  out  1  one-cycle pulse: complete, accepted frame received
- frame_err  out  1  one-cycle pulse: frame truncated or header mismatch

Behaviour:
- Reset: all outputs are 0, counters are 0, and state is WaitIdle.
- Byte assembly:
  - A 2-bit dibit counter increments on each cycle with axiiv high.
  - byte = {d3,d2,d1,d0}, where d0 is the first dibit.
  - A byte strobe fires on the cycle the 4th dibit is sampled.
  - The dibit counter clears whenever axiiv is low.
- Latency: pixel/audio outputs are registered and appear exactly 1 cycle after the 4th dibit of their byte is sampled.
- States:
  - WaitIdle: on reset; go to Idle once axiiv is sampled low. This guarantees a mid-frame reset never decodes a partial frame.
  - Idle: go to RecvHead when axiiv is high. That cycle's dibit is d0 of header byte 0.
  - RecvHead: 14 bytes. Bytes 0-5 are the destination MAC (MSB first), 6-11 are the source MAC (ignored), 12-13 are the ethertype (MSB first). After byte 13, go to RecvPixels if the destination is MY_MAC or broadcast and the ethertype equals ETHERTYPE; otherwise go to Drop.
  - RecvPixels: emit each byte on pixel_axiov with pixel_index = pixel counter, then increment. After byte PIXEL_BYTES-1, go to RecvAudio.
  - RecvAudio: same as RecvPixels on the audio port. After byte AUDIO_BYTES-1, go to RecvTail.
  - RecvTail: consume TAIL_BYTES bytes with no output, then go to Done.
  - Done: ignore any further bytes; when axiiv falls, pulse frame_done and go to Idle.
  - Drop: no data outputs; when axiiv falls, go to Idle. frame_err was already pulsed on the mismatch-detect cycle.
- Truncation: if axiiv falls in RecvHead, RecvPixels, RecvAudio or RecvTail:
  - discard any partial byte;
  - pulse frame_err on the cycle after axiiv is sampled low;
  - go to Idle;
  - keep bytes already emitted (downstream uses frame_err to discard them).
- frame_done and frame_err never assert in the same cycle, and each is at most one pulse per frame.
- Counters:
  - The pixel and audio counters are 9 bits and reset to 0 on entry to RecvHead. They never wrap within a frame.
  - The header byte counter is 4 bits; the tail counter is 3 bits.
- Output hold: pixel_axiod and audio_axiod hold their last value when not valid; valid signals are 0 except on strobes.
- Min inter-frame gap: 1 low cycle of axiiv is sufficient.

Decomposition:
- Package ethernet_pkg holds:
  - the state enum (WaitIdle, Idle, RecvHead, RecvPixels, RecvAudio, RecvTail, Done, Drop);
  - HEADER_BYTES = 14;
  - BROADCAST_MAC;
  - the default MAC and ethertype constants, shared with the FPGA1 packager.
- Sub-module dibit_to_byte: the dibit counter plus shift register. Outputs a byte plus a byte strobe, and clears on axiiv low.

Test Plan:
- Good frame: dest MY_MAC, type 16'h4C42, pixel bytes i%256, audio bytes 8'hA0+(i%16), 4 FCS bytes, then axiiv low → 320 pixel pulses with index 0..319 and matching data, then 160 audio pulses with index 0..159, each 1 cycle after its 4th dibit; one frame_done; no frame_err.
- Dibit order: first pixel byte sent as dibits 2'b01, 2'b10, 2'b11, 2'b00 → pixel_axiod = 8'h39.
- Broadcast destination → accepted. Dest 48'h0 or ethertype 16'h0800 → zero data pulses, one frame_err, no frame_done.
- Truncation: axiiv drops after 100 pixel bytes plus 2 dibits → exactly 100 pixel pulses and one frame_err; a following good frame decodes fully.
- Reset asserted mid-pixel stream with axiiv still high → all outputs 0 during and after reset, no outputs until axiiv goes low; the next frame decodes correctly.
- Back-to-back frames with a 1-cycle gap, plus 3 trailing junk bytes after the FCS → both frames are decoded, junk is ignored, and there are two frame_done pulses.
